pattern_search_engine: RTL and testbench
========================================

Name: pattern_search_engine

Overview:
- Parametrised sequential pattern-search accelerator; scans a block of single-port BRAM for a byte pattern of run-time length and reports match address(es).
- Sits between the top-level control inputs (start/continue) and the blk_mem_gen read port. It owns the BRAM address/enable while busy.
- Supersedes the fixed 2-bit, single-shot search.
- Adds:
  - multi-byte patterns
  - base address
  - find-first with resume
  - count-all mode
  - length error detection

Parameters:
- DATA_W, 8, memory word and pattern element width in bits
- ADDR_W, 8, BRAM address width
- MAX_PAT, 8, maximum pattern length in words
- RD_LAT, 1, BRAM read latency in cycles (≥1)

Ports:
- CLK100MHZ  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches operands and begins search
- cont  in  1  one-cycle pulse; resume after a find-first match
- mode  in  1  0 = find-first/resume, 1 = count-all
- pattern  in  MAX_PAT*DATA_W  word j occupies bits [j*DATA_W +: DATA_W]
- pat_len  in  $clog2(MAX_PAT+1)  pattern length in words
- base_addr  in  ADDR_W  first BRAM address of the block
- blk_len  in  ADDR_W+1  block length in words
- mem_en  out  1  BRAM enable
- mem_addr  out  ADDR_W  BRAM address
- mem_dout  in  DATA_W  BRAM read data
- busy  out  1  search in progress
- done  out  1  level; search stopped (match in mode 0, or end of block)
- found  out  1  at least one match since start
- err  out  1  illegal lengths
- match_addr  out  ADDR_W  absolute address of the first word of the most recent match
- match_count  out  ADDR_W+1  matches counted since start, saturating

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0.
- start is accepted in IDLE or DONE; ignored while busy.
  - Latches pattern, pat_len, base_addr, blk_len and mode.
  - Clears found, match_count, done and err.
  - Sets offset i=0 and j=0.
- Length check on the latched values: if pat_len==0, pat_len>MAX_PAT or pat_len>blk_len, go to DONE next cycle with err=1 and found=0. No BRAM access.
- States and transitions:
  - IDLE
  - ISSUE: mem_en=1, mem_addr=(base_addr+i+j) mod 2^ADDR_W, then WAIT.
  - WAIT: RD_LAT cycles, then CMP.
  - CMP: compares mem_dout with pattern word j.
    - Mismatch: j=0, i=i+1.
    - Match with j<pat_len-1: j=j+1.
    - Match with j==pat_len-1: full match.
    - After CMP, next state is ISSUE if i ≤ blk_len-pat_len, else DONE.
  - DONE
- Cycle cost: each word comparison takes exactly RD_LAT+2 cycles.
- Full match:
  - match_addr ← base_addr+i.
  - match_count increments and saturates at 2^(ADDR_W+1)-1.
  - found ← 1.
  - Then j=0, i=i+1, so overlapping matches are detected.
  - mode 0: go to DONE with done=1.
  - mode 1: continue scanning.
- Exhaustion (i > blk_len-pat_len): DONE, done=1, busy=0.
- cont:
  - Accepted only in DONE when mode==0, found==1 and i ≤ blk_len-pat_len.
  - Clears done and goes to ISSUE at the stored i. found and match_count are kept.
  - Otherwise ignored.
- start and cont asserted in the same cycle: start wins.
- busy=1 in ISSUE, WAIT and CMP only. mem_en=0 outside ISSUE and WAIT.
- Address wrap: base_addr+offset wraps modulo 2^ADDR_W. There is no bounds error for wrap.
- Async reset mid-search: state returns to IDLE and all outputs clear immediately. There is no partial result.
- Operand inputs may change freely after start; only the latched copies are used.

Optional Feature:
- Macro: PSE_MASK_EN
- Defined:
  - Adds input pat_mask [MAX_PAT-1:0].
  - Latched at start.
  - A word j with pat_mask[j]=1 is don't-care and always compares equal.
  - Its ISSUE/WAIT/CMP cycles are still spent, so timing is identical.
- Undefined: the port is absent and every pattern word is compared.

Test Plan:
- BRAM[0x10..0x17] = 41 42 41 42 43 00 00 00. mode=0, pattern 41 42 43, pat_len=3, base=0x10, blk_len=8.
  - Required: done=1, found=1, match_addr=0x12, match_count=1.
  - Then cont → done=1, found=1, match_count=1, match_addr=0x12 (exhausted).
- Same memory, mode=1, pattern 41 42, pat_len=2.
  - Required: done=1, match_count=2, match_addr=0x12.
  - With RD_LAT=1, total busy cycles = 3×(number of CMPs).
- BRAM[0x00..0x03] = 41 41 41 41, pattern 41 41, mode=1, blk_len=4.
  - Required: match_count=3 (overlap), match_addr=0x02.
- Wrap: base=0xFE, blk_len=4, BRAM[0xFE]=AA, BRAM[0xFF]=BB, BRAM[0x00]=CC, pattern BB CC.
  - Required: found=1, match_addr=0xFF.
- pat_len=0; then pat_len=9; then pat_len=5 with blk_len=4.
  - Required, each case: done=1, err=1, found=0, and mem_en never asserted.
- reset=0 pulsed during WAIT of a mode-1 search.
  - Required: all outputs 0 the same cycle.
  - A subsequent start runs correctly from offset 0.
- PSE_MASK_EN: pattern 41 xx 43, mask=3'b010 on the first memory set.
  - Required: match_addr=0x12.

Source files
------------

// File: rtl/pattern_search_engine_if.sv
// BRAM read-port bundle shared by pattern_search_engine (master) and the memory (slave).
interface pattern_search_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;

  modport master (output mem_en, output mem_addr, input mem_dout);
  modport slave  (input mem_en, input mem_addr, output mem_dout);
endinterface

// File: rtl/pattern_search_engine.sv
// Sequential BRAM pattern search: find-first with resume, or count-all with overlap.
// Optional macro PSE_MASK_EN adds per-word don't-care mask input pat_mask.
module pattern_search_engine #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MAX_PAT = 8,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                              CLK100MHZ,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              cont,
  input  logic                              mode,
  input  logic [MAX_PAT*DATA_W-1:0]         pattern,
  input  logic [$clog2(MAX_PAT+1)-1:0]      pat_len,
  input  logic [ADDR_W-1:0]                 base_addr,
  input  logic [ADDR_W:0]                   blk_len,
`ifdef PSE_MASK_EN
  input  logic [MAX_PAT-1:0]                pat_mask,
`endif
  pattern_search_engine_if.master           mem,
  output logic                              busy,
  output logic                              done,
  output logic                              found,
  output logic                              err,
  output logic [ADDR_W-1:0]                 match_addr,
  output logic [ADDR_W:0]                   match_count
);

  localparam int unsigned PL_W  = $clog2(MAX_PAT + 1);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned WC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [PL_W-1:0] MAX_PAT_L = PL_W'(MAX_PAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [MAX_PAT*DATA_W-1:0]   pattern_q, pattern_d;
  logic [PL_W-1:0]             pat_len_q, pat_len_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic [CNT_W-1:0]            blk_len_q, blk_len_d;
  logic                        mode_q, mode_d;
  logic [MAX_PAT-1:0]          mask_q, mask_d;
  logic [CNT_W-1:0]            i_q, i_d;
  logic [PL_W-1:0]             j_q, j_d;
  logic [WC_W-1:0]             wait_q, wait_d;
  logic                        found_q, found_d;
  logic                        err_q, err_d;
  logic [ADDR_W-1:0]           match_addr_q, match_addr_d;
  logic [CNT_W-1:0]            match_count_q, match_count_d;

  logic [CNT_W-1:0]            limit;
  logic [DATA_W-1:0]           pat_word;
  logic                        mask_bit;
  logic                        word_eq;
  logic                        len_bad;
  logic                        full_match;
  logic [ADDR_W-1:0]           rd_addr;

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pattern_q     <= '0;
      pat_len_q     <= '0;
      base_q        <= '0;
      blk_len_q     <= '0;
      mode_q        <= 1'b0;
      mask_q        <= '0;
      i_q           <= '0;
      j_q           <= '0;
      wait_q        <= '0;
      found_q       <= 1'b0;
      err_q         <= 1'b0;
      match_addr_q  <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      pat_len_q     <= pat_len_d;
      base_q        <= base_d;
      blk_len_q     <= blk_len_d;
      mode_q        <= mode_d;
      mask_q        <= mask_d;
      i_q           <= i_d;
      j_q           <= j_d;
      wait_q        <= wait_d;
      found_q       <= found_d;
      err_q         <= err_d;
      match_addr_q  <= match_addr_d;
      match_count_q <= match_count_d;
    end
  end

  // Pattern word and mask bit for the current offset j.
  always_comb begin
    pat_word = '0;
    mask_bit = 1'b0;
    for (int unsigned k = 0; k < MAX_PAT; k++) begin
      if (j_q == PL_W'(k)) begin
        pat_word = pattern_q[k*DATA_W +: DATA_W];
        mask_bit = mask_q[k];
      end
    end
  end

  assign word_eq = (mem.mem_dout == pat_word) || mask_bit;
  assign limit   = blk_len_q - CNT_W'(pat_len_q);
  assign len_bad = (pat_len == '0) || (pat_len > MAX_PAT_L) ||
                   (CNT_W'(pat_len) > blk_len);
  assign rd_addr = base_q + i_q[ADDR_W-1:0] + ADDR_W'(j_q);

  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    pat_len_d     = pat_len_q;
    base_d        = base_q;
    blk_len_d     = blk_len_q;
    mode_d        = mode_q;
    mask_d        = mask_q;
    i_d           = i_q;
    j_d           = j_q;
    wait_d        = wait_q;
    found_d       = found_q;
    err_d         = err_q;
    match_addr_d  = match_addr_q;
    match_count_d = match_count_q;
    full_match    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pattern_d     = pattern;
          pat_len_d     = pat_len;
          base_d        = base_addr;
          blk_len_d     = blk_len;
          mode_d        = mode;
`ifdef PSE_MASK_EN
          mask_d        = pat_mask;
`else
          mask_d        = '0;
`endif
          i_d           = '0;
          j_d           = '0;
          found_d       = 1'b0;
          err_d         = len_bad;
          match_count_d = '0;
          state_d       = len_bad ? S_DONE : S_ISSUE;
        end else if (state_q == S_DONE && cont && !mode_q && found_q &&
                     (i_q <= limit)) begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wait_q == WC_W'(RD_LAT - 1)) begin
          state_d = S_CMP;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end

      S_CMP: begin
        if (word_eq && (j_q != pat_len_q - PL_W'(1))) begin
          j_d = j_q + PL_W'(1);
        end else begin
          full_match = word_eq;
          j_d        = '0;
          i_d        = i_q + CNT_W'(1);
        end
        if (full_match) begin
          match_addr_d = base_q + i_q[ADDR_W-1:0];
          found_d      = 1'b1;
          if (match_count_q != '1) begin
            match_count_d = match_count_q + CNT_W'(1);
          end
        end
        // A find-first hit stops even when offsets remain; cont resumes from i_d.
        if (full_match && !mode_q) begin
          state_d = S_DONE;
        end else if (i_d <= limit) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mem_en   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign mem.mem_addr = mem.mem_en ? rd_addr : '0;
  assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CMP);
  assign done         = (state_q == S_DONE);
  assign found        = found_q;
  assign err          = err_q;
  assign match_addr   = match_addr_q;
  assign match_count  = match_count_q;

endmodule

// File: tb/tb_pattern_search_engine.sv
// Directed, table-driven bench for pattern_search_engine with a 1-cycle BRAM model.
module tb_pattern_search_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cont, mode;
  logic [63:0] pattern;
  logic [3:0]  pat_len;
  logic [7:0]  base_addr;
  logic [8:0]  blk_len;
  logic [7:0]  pat_mask;
  logic        busy, done, found, err;
  logic [7:0]  match_addr;
  logic [8:0]  match_count;

  logic [7:0]  mem_arr [256];

  int n_checks = 0;
  int n_pass   = 0;

  pattern_search_engine_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  pattern_search_engine #(
    .DATA_W(8), .ADDR_W(8), .MAX_PAT(8), .RD_LAT(1)
  ) dut (
    .CLK100MHZ   (clk),
    .reset       (rst_n),
    .start       (start),
    .cont        (cont),
    .mode        (mode),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .base_addr   (base_addr),
    .blk_len     (blk_len),
`ifdef PSE_MASK_EN
    .pat_mask    (pat_mask),
`endif
    .mem         (bus),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .err         (err),
    .match_addr  (match_addr),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_dout <= mem_arr[bus.mem_addr];
  end

  typedef struct {
    int          set;
    bit          mode;
    logic [63:0] pattern;
    logic [3:0]  pat_len;
    logic [7:0]  base;
    logic [8:0]  blk;
    logic [7:0]  mask;
    bit          do_cont;
    bit          exp_found;
    bit          exp_err;
    bit          chk_addr;
    logic [7:0]  exp_addr;
    logic [8:0]  exp_count;
    int          exp_busy;
    bit          c_found;
    logic [7:0]  c_addr;
    logic [8:0]  c_count;
    int          c_busy;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic load_mem(input int set);
    for (int a = 0; a < 256; a++) mem_arr[a] = 8'h00;
    case (set)
      0: begin
        mem_arr[8'h10] = 8'h41; mem_arr[8'h11] = 8'h42; mem_arr[8'h12] = 8'h41;
        mem_arr[8'h13] = 8'h42; mem_arr[8'h14] = 8'h43;
      end
      1: for (int a = 0; a < 4; a++) mem_arr[a] = 8'h41;
      default: begin
        mem_arr[8'hFE] = 8'hAA; mem_arr[8'hFF] = 8'hBB; mem_arr[8'h00] = 8'hCC;
      end
    endcase
  endtask

  task automatic do_start(input vec_t v);
    @(posedge clk); #1;
    start     = 1'b1;
    mode      = v.mode;
    pattern   = v.pattern;
    pat_len   = v.pat_len;
    base_addr = v.base;
    blk_len   = v.blk;
    pat_mask  = v.mask;
    @(posedge clk); #1;
    start     = 1'b0;
    mode      = ~v.mode;
    pattern   = '1;
    pat_len   = 4'd1;
    base_addr = 8'h55;
    blk_len   = '0;
    pat_mask  = '0;
  endtask

  task automatic wait_done(output int busy_c, output int en_c, output bit ok);
    busy_c = 0; en_c = 0; ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (busy) busy_c++;
      if (bus.mem_en) en_c++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   bc, ec;
    bit   ok;
    string p;
    v = vecs[idx];
    p = $sformatf("v%0d", idx);
    load_mem(v.set);
    do_start(v);
    wait_done(bc, ec, ok);
    check({p, ".done"},  32'(ok), 32'd1);
    check({p, ".found"}, 32'(found), 32'(v.exp_found));
    check({p, ".err"},   32'(err), 32'(v.exp_err));
    check({p, ".count"}, 32'(match_count), 32'(v.exp_count));
    check({p, ".busy_cycles"}, 32'(bc), 32'(v.exp_busy));
    if (v.chk_addr) check({p, ".addr"}, 32'(match_addr), 32'(v.exp_addr));
    if (v.exp_err)  check({p, ".no_mem_en"}, 32'(ec), 32'd0);
    if (v.do_cont) begin
      @(posedge clk); #1; cont = 1'b1;
      @(posedge clk); #1; cont = 1'b0;
      wait_done(bc, ec, ok);
      check({p, ".cont_done"},  32'(ok), 32'd1);
      check({p, ".cont_found"}, 32'(found), 32'(v.c_found));
      check({p, ".cont_addr"},  32'(match_addr), 32'(v.c_addr));
      check({p, ".cont_count"}, 32'(match_count), 32'(v.c_count));
      check({p, ".cont_busy"},  32'(bc), 32'(v.c_busy));
    end
  endtask

  task automatic check_all_zero(input string p);
    check({p, ".busy"},     32'(busy), 32'd0);
    check({p, ".done"},     32'(done), 32'd0);
    check({p, ".found"},    32'(found), 32'd0);
    check({p, ".err"},      32'(err), 32'd0);
    check({p, ".addr"},     32'(match_addr), 32'd0);
    check({p, ".count"},    32'(match_count), 32'd0);
    check({p, ".mem_en"},   32'(bus.mem_en), 32'd0);
    check({p, ".mem_addr"}, 32'(bus.mem_addr), 32'd0);
  endtask

  initial begin
    //           set mode  pattern        len    base   blk    mask   cont  fnd   err   chka  addr   count  busy  cfnd  caddr  ccnt   cbusy
    vecs[0] = '{0, 1'b0, 64'h434241, 4'd3, 8'h10, 9'd8, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 9'd1, 21, 1'b1, 8'h12, 9'd1, 9};
    vecs[1] = '{0, 1'b1, 64'h4241,   4'd2, 8'h10, 9'd8, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 9'd2, 27, 1'b1, 8'h12, 9'd2, 0};
    vecs[2] = '{1, 1'b1, 64'h4141,   4'd2, 8'h00, 9'd4, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 9'd3, 18, 1'b0, 8'h00, 9'd0, 0};
    vecs[3] = '{2, 1'b0, 64'hCCBB,   4'd2, 8'hFE, 9'd4, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 9'd1, 9,  1'b0, 8'h00, 9'd0, 0};
    vecs[4] = '{0, 1'b0, 64'h41,     4'd0, 8'h10, 9'd8, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 9'd0, 0,  1'b0, 8'h00, 9'd0, 0};
    vecs[5] = '{0, 1'b0, 64'h41,     4'd9, 8'h10, 9'd8, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 9'd0, 0,  1'b0, 8'h00, 9'd0, 0};
    vecs[6] = '{0, 1'b1, 64'h41,     4'd5, 8'h10, 9'd4, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 9'd0, 0,  1'b0, 8'h00, 9'd0, 0};
`ifdef PSE_MASK_EN
    vecs[7] = '{0, 1'b0, 64'h430041, 4'd3, 8'h10, 9'd8, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 9'd1, 21, 1'b0, 8'h00, 9'd0, 0};
`else
    vecs[7] = '{0, 1'b0, 64'h430041, 4'd3, 8'h10, 9'd8, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0, 24, 1'b0, 8'h00, 9'd0, 0};
`endif

    rst_n = 1'b0; start = 1'b0; cont = 1'b0; mode = 1'b0;
    pattern = '0; pat_len = '0; base_addr = '0; blk_len = '0; pat_mask = '0;
    load_mem(0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(k);

    // Reset during the WAIT of the third comparison of a count-all search.
    load_mem(0);
    do_start(vecs[1]);
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst.found",  32'(found), 32'd1);
    check("pre_rst.busy",   32'(busy), 32'd1);
    check("pre_rst.mem_en", 32'(bus.mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk); rst_n = 1'b1;
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
